// File: rtl/elm_output_scheduler.sv
// elm_output_scheduler: sequences one shared fixed-latency Q6.15 multiplier
// over NUM hidden-layer outputs and their output weights, accumulates the
// products onto a bias and emits one saturated 21-bit output-neuron score.
module elm_output_scheduler #(
  parameter int N       = 21,
  parameter int AW      = 7,
  parameter int ACC_W   = 28,
  parameter int MUL_LAT = 21
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_hidden,
  input  logic [N-1:0]  bias,
  output logic [AW-1:0] h_addr,
  input  logic [N-1:0]  h_data,
  output logic [AW-1:0] w_addr,
  input  logic [N-1:0]  w_data,
  output logic [N-1:0]  mul_M,
  output logic [N-1:0]  mul_Q,
  output logic          mul_ready,
  input  logic [N-1:0]  mul_product,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          overflow
);

  localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MUL_LAT - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [N-1:0] RES_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] RES_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]            index;
  logic [AW:0]              count;
  logic [WW-1:0]            wait_cnt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [ACC_W-1:0]  bias_ext, prod_ext;
  logic                     last, wait_end;

  assign bias_ext = {{(ACC_W-N){bias[N-1]}}, bias};
  assign prod_ext = {{(ACC_W-N){mul_product[N-1]}}, mul_product};
  assign last     = ({1'b0, index} == (count - CNT_ONE));
  assign wait_end = (wait_cnt == WAIT_LAST);

  assign h_addr = index;
  assign w_addr = index;
  assign mul_M  = h_data;
  assign mul_Q  = w_data;
  assign done   = (state == S_DONE);
  assign busy   = (state == S_FETCH) || (state == S_LOAD) ||
                  (state == S_WAIT)  || (state == S_ACCUM);
  // DONE keeps ready high as well, so the multiplier stays cleared and a
  // zero-length run never drops ready.
  assign mul_ready = reset || (state == S_IDLE) || (state == S_LOAD) ||
                     (state == S_DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state sequencing and accumulator update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt   = bias_ext;
          state_nxt = (num_hidden == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_end) state_nxt = S_ACCUM;
      S_ACCUM: begin
        acc_nxt   = acc + prod_ext;
        state_nxt = last ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: count/index, latency counter, accumulator, result.
  always_ff @(posedge clock) begin
    if (reset) begin
      index    <= '0;
      count    <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if ((state == S_IDLE) && start) begin
        count <= num_hidden;
        index <= '0;
      end
      if (state == S_LOAD)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + WW'(1);
      if ((state == S_ACCUM) && !last)
        index <= index + AW'(1);
      // Result is registered on entry to DONE so it is valid while done is high.
      if (state_nxt == S_DONE) begin
        if (acc_nxt > SAT_MAX) begin
          result   <= RES_MAX;
          overflow <= 1'b1;
        end else if (acc_nxt < SAT_MIN) begin
          result   <= RES_MIN;
          overflow <= 1'b1;
        end else begin
          result   <= acc_nxt[N-1:0];
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
